// File: rtl/wb_host_arbiter.sv
// wb_host_arbiter
// Two-master, one-slave Wishbone arbiter. It shares the SoC slave port
// between the Caravel management bus (master 0) and a logic-analyzer
// debug master (master 1). Masters are granted round-robin, and a grant is
// held until the transaction ends. A watchdog ends any transaction that the
// slave never acknowledges.
//
// Parameters
//   TIMEOUT   granted cycles allowed without s_ack_i before a forced end (1..65535)
//   ERR_DATA  read data returned to the master when the watchdog fires
//
// Ports
//   wb_clk_i, rst_ni           clock, asynchronous active-low reset
//   m0_* / m1_*                master request (cyc/stb/we/sel/adr/dat) and response (ack/dat)
//   s_*                        request to the slave, plus slave ack/data
//   timeout_o                  one-cycle pulse when the watchdog fires
//   grant_o                    one-hot grant (bit 0 = master 0), 00 when idle
module wb_host_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        wb_clk_i,
   input  logic        rst_ni,

   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,

   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,

   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,

   output logic        timeout_o,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   // The watchdog counts from 0 in the first granted cycle, so it reaches
   // this value in the TIMEOUT-th granted cycle.
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_next;
   logic        prio, prio_next;
   logic [15:0] wdog, wdog_next;

   logic        req0, req1;
   logic        granted;
   logic        g_cyc, g_stb, g_we;
   logic [3:0]  g_sel;
   logic [31:0] g_adr, g_dat;
   logic        expire;
   logic        done;
   logic        resp_ack;
   logic [31:0] resp_dat;

   // Register stage: state, round-robin pointer and watchdog counter.
   // Reset is asynchronous, so every output derived from state falls to its
   // idle value as soon as rst_ni goes low, without waiting for a clock edge.
   always_ff @(posedge wb_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         prio  <= 1'b0;
         wdog  <= 16'd0;
      end else begin
         state <= state_next;
         prio  <= prio_next;
         wdog  <= wdog_next;
      end
   end

   // Datapath: pick the granted master's request and decide whether this
   // cycle ends the transaction. A slave ack in the expiry cycle counts as a
   // normal completion, so expiry is qualified with !s_ack_i. A master that
   // has dropped cyc is aborting, and an abort never raises a timeout.
   always_comb begin
      req0    = m0_cyc_i & m0_stb_i;
      req1    = m1_cyc_i & m1_stb_i;
      granted = (state == G0) || (state == G1);

      if (state == G1) begin
         g_cyc = m1_cyc_i;
         g_stb = m1_stb_i;
         g_we  = m1_we_i;
         g_sel = m1_sel_i;
         g_adr = m1_adr_i;
         g_dat = m1_dat_i;
      end else begin
         g_cyc = m0_cyc_i;
         g_stb = m0_stb_i;
         g_we  = m0_we_i;
         g_sel = m0_sel_i;
         g_adr = m0_adr_i;
         g_dat = m0_dat_i;
      end

      expire   = granted && g_cyc && !s_ack_i && (wdog == WDOG_LAST);
      done     = granted && (s_ack_i || !g_cyc || expire);
      resp_ack = s_ack_i | expire;
      resp_dat = expire ? ERR_DATA : s_dat_i;
   end

   // Output stage: in IDLE everything going to the slave is held at zero.
   // While granted, the request passes straight through, except that cyc and
   // stb are pulled low in the cycle the watchdog fires. The response goes
   // back only to the granted master.
   always_comb begin
      s_cyc_o   = granted & g_cyc & ~expire;
      s_stb_o   = granted & g_stb & ~expire;
      s_we_o    = granted & g_we;
      s_sel_o   = granted ? g_sel : 4'd0;
      s_adr_o   = granted ? g_adr : 32'd0;
      s_dat_o   = granted ? g_dat : 32'd0;

      m0_ack_o  = (state == G0) & resp_ack;
      m0_dat_o  = (state == G0) ? resp_dat : 32'd0;
      m1_ack_o  = (state == G1) & resp_ack;
      m1_dat_o  = (state == G1) ? resp_dat : 32'd0;

      timeout_o = expire;
      grant_o   = {state == G1, state == G0};
   end

   // Next-state logic. IDLE breaks ties with prio. Every transaction that
   // ends, whether by ack, abort or timeout, hands priority to the other
   // master. Because every grant starts from IDLE, clearing wdog in IDLE
   // makes each grant begin counting from zero.
   always_comb begin
      state_next = state;
      prio_next  = prio;
      wdog_next  = wdog;

      case (state)
         IDLE: begin
            wdog_next = 16'd0;
            if (req0 && req1)
               state_next = prio ? G1 : G0;
            else if (req0)
               state_next = G0;
            else if (req1)
               state_next = G1;
         end
         G0, G1: begin
            if (done) begin
               state_next = IDLE;
               prio_next  = (state == G0);
            end else begin
               wdog_next = wdog + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// tb_wb_host_arbiter
// Directed bench for wb_host_arbiter with TIMEOUT = 8. Inputs change 2 time
// units after each rising edge. Outputs are checked 1 time unit after that,
// which keeps every sample well away from the clock edges.
module tb_wb_host_arbiter;

   logic        wb_clk_i = 1'b0;
   logic        rst_ni   = 1'b0;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic        m0_ack_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic        m1_ack_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;
   logic        timeout_o;
   logic [1:0]  grant_o;

   int errors = 0;
   int checks = 0;

   wb_host_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .wb_clk_i(wb_clk_i), .rst_ni(rst_ni),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .timeout_o(timeout_o), .grant_o(grant_o)
   );

   // 10-unit clock
   always #5 wb_clk_i = ~wb_clk_i;

   // Absolute time limit so that the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] time limit");
   end

   // Advance one clock, then settle 2 units past the edge
   task automatic step();
      @(posedge wb_clk_i);
      #2;
   endtask

   task automatic idle_masters();
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
   endtask

   task automatic drive_m0(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
   endtask

   task automatic drive_m1(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
   endtask

   task automatic do_reset();
      idle_masters();
      s_ack_i = 0;
      s_dat_i = 0;
      rst_ni  = 0;
      repeat (2) @(posedge wb_clk_i);
      #2;
      rst_ni = 1;
   endtask

   task automatic test_reset();
      idle_masters();
      s_ack_i = 0;
      s_dat_i = 32'h1111_2222;
      rst_ni  = 0;
      #3;
      checks++; if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b want 00", grant_o); end
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o); end
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); end
      checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_acks: got %b%b want 00", m0_ack_o, m1_ack_o); end
      checks++; if (m0_dat_o !== 32'd0 || m1_dat_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_dat: got %h %h want 0", m0_dat_o, m1_dat_o); end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_0004, 32'd0);
      #1;
      checks++; if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL read_grant_N: got %b want 00", grant_o); end
      step(); #1;
      checks++; if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL read_grant_N1: got %b want 01", grant_o); end
      checks++; if (s_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL read_stb_N1: got %b want 1", s_stb_o); end
      checks++; if (s_adr_o !== 32'h3000_0004) begin errors++; $display("[TB] FAIL read_adr: got %h want 30000004", s_adr_o); end
      checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL read_early_ack: got %b want 0", m0_ack_o); end
      step(); #1;
      checks++; if (m0_ack_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("[TB] FAIL read_wait: got ack=%b grant=%b want 0/01", m0_ack_o, grant_o); end
      step();
      s_ack_i = 1; s_dat_i = 32'h1234_5678;
      #1;
      checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL read_ack: got %b want 1", m0_ack_o); end
      checks++; if (m0_dat_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_data: got %h want 12345678", m0_dat_o); end
      checks++; if (m1_ack_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL read_other: got m1_ack=%b timeout=%b want 0/0", m1_ack_o, timeout_o); end
      step();
      idle_masters(); s_ack_i = 0; s_dat_i = 0;
      #1;
      checks++; if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL read_idle_after: got %b want 00", grant_o); end
      checks++; if (dut.prio !== 1'b1) begin errors++; $display("[TB] FAIL read_prio: got %b want 1", dut.prio); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_grant [7];
      exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_0100, 32'd0);
      drive_m1(1'b0, 4'hF, 32'h3000_0200, 32'd0);
      for (int i = 0; i < 7; i++) begin
         step();
         s_ack_i = (exp_grant[i] != 2'b00);
         s_dat_i = 32'h0000_0A00 + 32'(i);
         #1;
         checks++; if (grant_o !== exp_grant[i]) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", i, grant_o, exp_grant[i]); end
         if (exp_grant[i] == 2'b01) begin
            checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_adr_o !== 32'h3000_0100) begin errors++; $display("[TB] FAIL rr_m0[%0d]: got ack=%b%b adr=%h want 0 1 30000100", i, m1_ack_o, m0_ack_o, s_adr_o); end
         end else if (exp_grant[i] == 2'b10) begin
            checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_adr_o !== 32'h3000_0200) begin errors++; $display("[TB] FAIL rr_m1[%0d]: got ack=%b%b adr=%h want 1 0 30000200", i, m1_ack_o, m0_ack_o, s_adr_o); end
         end
      end
      step();
      s_ack_i = 0;
      idle_masters();
   endtask

   task automatic test_m1_write();
      do_reset();
      drive_m1(1'b1, 4'b0011, 32'h3000_0010, 32'hA5A5_0000);
      step();
      s_ack_i = 1; s_dat_i = 32'h5555_5555;
      #1;
      checks++; if (grant_o !== 2'b10) begin errors++; $display("[TB] FAIL wr_grant: got %b want 10", grant_o); end
      checks++; if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011) begin errors++; $display("[TB] FAIL wr_we_sel: got %b %b want 1 0011", s_we_o, s_sel_o); end
      checks++; if (s_dat_o !== 32'hA5A5_0000 || s_adr_o !== 32'h3000_0010) begin errors++; $display("[TB] FAIL wr_dat_adr: got %h %h want a5a50000 30000010", s_dat_o, s_adr_o); end
      checks++; if (m1_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_m1_ack: got %b want 1", m1_ack_o); end
      checks++; if (m0_ack_o !== 1'b0 || m0_dat_o !== 32'd0) begin errors++; $display("[TB] FAIL wr_m0_quiet: got %b %h want 0 0", m0_ack_o, m0_dat_o); end
      step();
      idle_masters(); s_ack_i = 0;
      #1;
      checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle_after: got %b %b want 00 0", grant_o, s_cyc_o); end
   endtask

   task automatic test_timeout();
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_0008, 32'd0);
      step();
      for (int c = 1; c < 8; c++) begin
         #1;
         checks++; if (s_cyc_o !== 1'b1 || m0_ack_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_wait[%0d]: got cyc=%b ack=%b to=%b want 1 0 0", c, s_cyc_o, m0_ack_o, timeout_o); end
         step();
      end
      #1;
      checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL to_ack: got %b %h want 1 deadbeef", m0_ack_o, m0_dat_o); end
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse: got %b want 1", timeout_o); end
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL to_s_cyc: got %b%b want 00", s_cyc_o, s_stb_o); end
      step();
      idle_masters();
      #1;
      checks++; if (grant_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_after: got %b %b want 00 0", grant_o, timeout_o); end
   endtask

   task automatic test_timeout_ack_race();
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_000C, 32'd0);
      repeat (8) step();
      s_ack_i = 1; s_dat_i = 32'hCAFE_0001;
      #1;
      checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL race_ack: got %b %h want 1 cafe0001", m0_ack_o, m0_dat_o); end
      checks++; if (timeout_o !== 1'b0 || s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL race_no_to: got to=%b cyc=%b want 0 1", timeout_o, s_cyc_o); end
      step();
      idle_masters(); s_ack_i = 0;
      #1;
      checks++; if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL race_after: got %b want 00", grant_o); end
   endtask

   task automatic test_abort();
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_0020, 32'd0);
      drive_m1(1'b0, 4'hF, 32'h3000_0030, 32'd0);
      step(); #1;
      checks++; if (grant_o !== 2'b01) begin errors++; $display("[TB] FAIL abort_grant0: got %b want 01", grant_o); end
      step(); step();
      step();
      m0_cyc_i = 0; m0_stb_i = 0;
      #1;
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_s_cyc: got %b%b want 00", s_cyc_o, s_stb_o); end
      checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ack: got %b%b want 00", m0_ack_o, m1_ack_o); end
      step(); #1;
      checks++; if (grant_o !== 2'b00) begin errors++; $display("[TB] FAIL abort_idle: got %b want 00", grant_o); end
      step(); #1;
      checks++; if (grant_o !== 2'b10 || s_adr_o !== 32'h3000_0030) begin errors++; $display("[TB] FAIL abort_m1_grant: got %b %h want 10 30000030", grant_o, s_adr_o); end
      s_ack_i = 1;
      step();
      s_ack_i = 0;
      idle_masters();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_m0(1'b0, 4'hF, 32'h3000_0040, 32'd0);
      step();
      s_ack_i = 1;
      step();
      s_ack_i = 0;
      idle_masters();
      drive_m1(1'b1, 4'hF, 32'h3000_0050, 32'h0BAD_F00D);
      step(); #1;
      checks++; if (grant_o !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_grant1: got %b want 10", grant_o); end
      step(); #1;
      rst_ni = 0;
      s_ack_i = 1;
      #1;
      checks++; if (grant_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_grant: got %b %b want 00 0", grant_o, timeout_o); end
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_s_ctl: got %b%b%b want 000", s_cyc_o, s_stb_o, s_we_o); end
      checks++; if (s_adr_o !== 32'd0 || s_dat_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_s_data: got %h %h want 0 0", s_adr_o, s_dat_o); end
      checks++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_m1: got %b %h want 0 0", m1_ack_o, m1_dat_o); end
      s_ack_i = 0;
      drive_m0(1'b0, 4'hF, 32'h3000_0060, 32'd0);
      step(); step();
      rst_ni = 1;
      step(); #1;
      checks++; if (grant_o !== 2'b01 || s_adr_o !== 32'h3000_0060) begin errors++; $display("[TB] FAIL rstmid_regrant: got %b %h want 01 30000060", grant_o, s_adr_o); end
      s_ack_i = 1;
      step();
      s_ack_i = 0;
      idle_masters();
   endtask

   initial begin
      idle_masters();
      s_ack_i = 0;
      s_dat_i = 0;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_m1_write();
      test_timeout();
      test_timeout_ack_race();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
